simmem_rsp_buf: RTL and testbench

SIMMEM_RSP_BUF -- requirements
Module: simmem_rsp_buf

---
 rtl/simmem_rsp_buf.sv | 208 ++++++++++++++++++++
 tb/tb_simmem_rsp_buf.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_rsp_buf.sv
// Response buffer for the simulated memory: slots are reserved per AXI ID, filled in per-ID order and released in slot order.
// Define SIMMEM_RSP_BUF_OUT_REG_EN to place a one-entry register in the output path.
module simmem_rsp_buf #(
  parameter int NumIds  = 4,
  parameter int TotCapa = 16,
  parameter int DataW   = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,

  input  logic [NumIds-1:0]          rsv_req_id_onehot_i,
  input  logic                       rsv_valid_i,
  output logic                       rsv_ready_o,
  output logic [$clog2(TotCapa)-1:0] rsv_iid_o,

  input  logic [$clog2(NumIds)-1:0]  in_rsp_id_i,
  input  logic [DataW-1:0]           rsp_i,
  input  logic                       in_rsp_valid_i,
  output logic                       in_rsp_ready_o,

  input  logic [TotCapa-1:0]         release_en_i,
  output logic [TotCapa-1:0]         released_addr_onehot_o,

  output logic [DataW-1:0]           rsp_o,
  output logic                       out_rsp_valid_o,
  input  logic                       out_rsp_ready_i,
  input  logic                       delay_calc_ready_i,
  output logic                       delay_calc_ready_o
);

  localparam int IdxW = $clog2(TotCapa);
  localparam int SeqW = IdxW + 1;
  localparam int IdW  = $clog2(NumIds);

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_RESERVED = 2'd1,
    SLOT_FILLED   = 2'd2
  } slot_state_e;

  slot_state_e      slot_state_q [TotCapa];
  logic [IdW-1:0]   slot_id_q    [TotCapa];
  logic [SeqW-1:0]  slot_seq_q   [TotCapa];
  logic [DataW-1:0] slot_data_q  [TotCapa];

  logic [SeqW-1:0]  rsv_cnt_q  [NumIds];
  logic [SeqW-1:0]  fill_cnt_q [NumIds];

  // Holds rsv_ready_o low after reset until a clock has seen the delay calculator ready.
  logic             alive_q;

  logic             any_free;
  logic [IdxW-1:0]  free_idx;
  logic [IdW-1:0]   rsv_id;
  logic             fill_hit;
  logic [IdxW-1:0]  fill_idx;
  logic             cand_any;
  logic [IdxW-1:0]  cand_idx;

  logic             rsv_fire;
  logic             fill_fire;
  logic             rel_fire;
  logic [IdxW-1:0]  rel_idx;

  logic [TotCapa-1:0] rsv_sel;
  logic [TotCapa-1:0] fill_sel;
  logic [TotCapa-1:0] rel_sel;

  always_comb begin
    // NOTE: every variable gets a default before the loops, so no path leaves it unassigned and no latch is inferred.
    any_free = 1'b0;
    free_idx = '0;
    rsv_id   = '0;
    fill_hit = 1'b0;
    fill_idx = '0;
    cand_any = 1'b0;
    cand_idx = '0;

    // Descending scans so the last hit written is the lowest index.
    for (int i = TotCapa - 1; i >= 0; i--) begin
      if (slot_state_q[i] == SLOT_FREE) begin
        any_free = 1'b1;
        free_idx = IdxW'(i);
      end
      if (slot_state_q[i] == SLOT_FILLED && release_en_i[i]) begin
        cand_any = 1'b1;
        cand_idx = IdxW'(i);
      end
      if (slot_state_q[i] == SLOT_RESERVED && slot_id_q[i] == in_rsp_id_i &&
          slot_seq_q[i] == fill_cnt_q[in_rsp_id_i]) begin
        fill_hit = 1'b1;
        fill_idx = IdxW'(i);
      end
    end

    for (int j = NumIds - 1; j >= 0; j--) begin
      if (rsv_req_id_onehot_i[j]) rsv_id = IdW'(j);
    end
  end

  // Decisions only look at registered slot state, so a slot freed this cycle
  // cannot be re-reserved and a slot reserved this cycle cannot be filled.
  assign rsv_ready_o        = any_free & delay_calc_ready_i & alive_q;
  assign rsv_iid_o          = free_idx;
  assign delay_calc_ready_o = any_free;
  assign in_rsp_ready_o     = fill_hit;

  assign rsv_fire  = rsv_valid_i & rsv_ready_o;
  assign fill_fire = in_rsp_valid_i & fill_hit;

  assign rsv_sel  = rsv_fire  ? (TotCapa'(1) << free_idx) : '0;
  assign fill_sel = fill_fire ? (TotCapa'(1) << fill_idx) : '0;
  assign rel_sel  = rel_fire  ? (TotCapa'(1) << rel_idx)  : '0;

  assign released_addr_onehot_o = rel_sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alive_q <= 1'b0;
      for (int i = 0; i < TotCapa; i++) begin
        slot_state_q[i] <= SLOT_FREE;
        slot_id_q[i]    <= '0;
        slot_seq_q[i]   <= '0;
      end
      for (int j = 0; j < NumIds; j++) begin
        rsv_cnt_q[j]  <= '0;
        fill_cnt_q[j] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments here so every slot update sees the pre-edge state.
      alive_q <= alive_q | delay_calc_ready_i;
      for (int i = 0; i < TotCapa; i++) begin
        if (rsv_sel[i]) begin
          slot_state_q[i] <= SLOT_RESERVED;
          slot_id_q[i]    <= rsv_id;
          slot_seq_q[i]   <= rsv_cnt_q[rsv_id];
        end
        if (fill_sel[i]) slot_state_q[i] <= SLOT_FILLED;
        if (rel_sel[i])  slot_state_q[i] <= SLOT_FREE;
      end
      if (rsv_fire)  rsv_cnt_q[rsv_id]       <= rsv_cnt_q[rsv_id] + SeqW'(1);
      if (fill_fire) fill_cnt_q[in_rsp_id_i] <= fill_cnt_q[in_rsp_id_i] + SeqW'(1);
    end
  end

  // NOTE: payload storage has no reset; it is only read while its slot state says FILLED.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < TotCapa; i++) begin
      if (fill_sel[i]) slot_data_q[i] <= rsp_i;
    end
  end

`ifdef SIMMEM_RSP_BUF_OUT_REG_EN

  logic             out_vld_q;
  logic [DataW-1:0] out_data_q;
  logic             move;

  // Refill whenever the register is empty or being drained this cycle.
  assign move     = cand_any & (~out_vld_q | out_rsp_ready_i);
  assign rel_fire = move;
  assign rel_idx  = cand_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (move) begin
      out_vld_q  <= 1'b1;
      out_data_q <= slot_data_q[cand_idx];
    end else if (out_rsp_ready_i) begin
      out_vld_q  <= 1'b0;
    end
  end

  assign out_rsp_valid_o = out_vld_q;
  assign rsp_o           = out_data_q;

`else

  // Once offered and stalled, the slot is locked so a newly enabled lower
  // candidate cannot replace the payload before the handshake.
  logic             hold_q;
  logic [IdxW-1:0]  hold_idx_q;
  logic             sel_valid;
  logic [IdxW-1:0]  sel_idx;

  assign sel_valid = hold_q | cand_any;
  assign sel_idx   = hold_q ? hold_idx_q : cand_idx;
  assign rel_fire  = sel_valid & out_rsp_ready_i;
  assign rel_idx   = sel_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      hold_q     <= sel_valid & ~out_rsp_ready_i;
      hold_idx_q <= sel_idx;
    end
  end

  assign out_rsp_valid_o = sel_valid;
  assign rsp_o           = sel_valid ? slot_data_q[sel_idx] : '0;

`endif

endmodule

// File: tb/tb_simmem_rsp_buf.sv
// Directed bench for simmem_rsp_buf with default parameters; expectations follow SIMMEM_RSP_BUF_OUT_REG_EN when defined.
module tb_simmem_rsp_buf;

  localparam int NumIds  = 4;
  localparam int TotCapa = 16;
  localparam int DataW   = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NumIds-1:0]   rsv_req_id_onehot;
  logic                rsv_valid;
  logic                rsv_ready;
  logic [3:0]          rsv_iid;
  logic [1:0]          in_rsp_id;
  logic [DataW-1:0]    rsp_in;
  logic                in_rsp_valid;
  logic                in_rsp_ready;
  logic [TotCapa-1:0]  release_en;
  logic [TotCapa-1:0]  released_addr_onehot;
  logic [DataW-1:0]    rsp_out;
  logic                out_rsp_valid;
  logic                out_rsp_ready;
  logic                delay_calc_ready_in;
  logic                delay_calc_ready_out;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [DataW-1:0]   data;
    logic [TotCapa-1:0] oh;
  } exp_t;

  exp_t exp_q[$];

  simmem_rsp_buf #(
    .NumIds (NumIds),
    .TotCapa(TotCapa),
    .DataW  (DataW)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .rsv_req_id_onehot_i   (rsv_req_id_onehot),
    .rsv_valid_i           (rsv_valid),
    .rsv_ready_o           (rsv_ready),
    .rsv_iid_o             (rsv_iid),
    .in_rsp_id_i           (in_rsp_id),
    .rsp_i                 (rsp_in),
    .in_rsp_valid_i        (in_rsp_valid),
    .in_rsp_ready_o        (in_rsp_ready),
    .release_en_i          (release_en),
    .released_addr_onehot_o(released_addr_onehot),
    .rsp_o                 (rsp_out),
    .out_rsp_valid_o       (out_rsp_valid),
    .out_rsp_ready_i       (out_rsp_ready),
    .delay_calc_ready_i    (delay_calc_ready_in),
    .delay_calc_ready_o    (delay_calc_ready_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic idle_inputs();
    rsv_req_id_onehot   = '0;
    rsv_valid           = 1'b0;
    in_rsp_id           = '0;
    rsp_in              = '0;
    in_rsp_valid        = 1'b0;
    release_en          = '0;
    out_rsp_ready       = 1'b0;
    delay_calc_ready_in = 1'b1;
  endtask

  // Asserts reset for one cycle, checks every reset-valued output, then releases.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check({tag, "_rsv_ready"}, rsv_ready, 1'b0);
    check({tag, "_out_valid"}, out_rsp_valid, 1'b0);
    check({tag, "_in_ready"}, in_rsp_ready, 1'b0);
    check({tag, "_released"}, released_addr_onehot, '0);
    check({tag, "_rsp_o"}, rsp_out, '0);
    check({tag, "_dcr_o"}, delay_calc_ready_out, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic reserve(input string tag, input int id, input int exp_iid);
    @(negedge clk);
    rsv_valid         = 1'b1;
    rsv_req_id_onehot = NumIds'(1) << id;
    #1;
    check({tag, "_rsv_ready"}, rsv_ready, 1'b1);
    check({tag, "_rsv_iid"}, rsv_iid, exp_iid);
    @(posedge clk);
    #1;
    rsv_valid = 1'b0;
  endtask

  task automatic fill(input string tag, input int id, input logic [DataW-1:0] data);
    @(negedge clk);
    in_rsp_valid = 1'b1;
    in_rsp_id    = 2'(id);
    rsp_in       = data;
    #1;
    check({tag, "_in_ready"}, in_rsp_ready, 1'b1);
    @(posedge clk);
    #1;
    in_rsp_valid = 1'b0;
  endtask

  // Drains the entries in exp_q with out_rsp_ready held high and checks order.
  task automatic drain(input string tag, input logic [TotCapa-1:0] en);
    int n;
    n = exp_q.size();
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        release_en    = en;
        out_rsp_ready = 1'b1;
      end
      #1;
`ifdef SIMMEM_RSP_BUF_OUT_REG_EN
      check({tag, "_released"}, released_addr_onehot, (k < n) ? exp_q[k].oh : '0);
      check({tag, "_valid"}, out_rsp_valid, k >= 1);
      if (k >= 1) check({tag, "_data"}, rsp_out, exp_q[k-1].data);
`else
      check({tag, "_released"}, released_addr_onehot, (k < n) ? exp_q[k].oh : '0);
      check({tag, "_valid"}, out_rsp_valid, k < n);
      if (k < n) check({tag, "_data"}, rsp_out, exp_q[k].data);
`endif
    end
    @(negedge clk);
    release_en    = '0;
    out_rsp_ready = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    idle_inputs();
    do_reset("rst0");

    // Three reservations on ID0 land in slots 0..2 with seq 0..2.
    @(negedge clk);
    delay_calc_ready_in = 1'b0;
    #1;
    check("dcr_gate_rsv_ready", rsv_ready, 1'b0);
    delay_calc_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) reserve("rsv_id0", 0, i);
    @(negedge clk);
    in_rsp_id = 2'd1;
    #1;
    check("unreserved_id1_ready", in_rsp_ready, 1'b0);
    for (int i = 0; i < 3; i++) fill("fill_id0", 0, 32'h100 + i);
    for (int i = 0; i < 3; i++) exp_q.push_back('{32'h100 + i, TotCapa'(1) << i});
    drain("drain_id0", '1);

    // ID1 payloads go to its reserved slots in order; ID2 is back-pressured.
    do_reset("rst1");
    reserve("rsv_id1", 1, 0);
    reserve("rsv_id1", 1, 1);
    @(negedge clk);
    in_rsp_id = 2'd2;
    #1;
    check("unreserved_id2_ready", in_rsp_ready, 1'b0);
    fill("fill_a", 1, 32'hA);
    fill("fill_b", 1, 32'hB);
    exp_q.push_back('{32'hA, 16'h0001});
    exp_q.push_back('{32'hB, 16'h0002});
    drain("drain_id1", '1);

    // Full buffer stops reservations; releasing one reopens both readies.
    do_reset("rst2");
    for (int i = 0; i < TotCapa; i++) reserve("rsv_full", i % NumIds, i);
    @(negedge clk);
    #1;
    check("full_rsv_ready", rsv_ready, 1'b0);
    check("full_dcr_o", delay_calc_ready_out, 1'b0);
    fill("fill_s1", 1, 32'h55);
    @(negedge clk);
    release_en    = 16'h0002;
    out_rsp_ready = 1'b1;
    #1;
    check("rel_s1_onehot", released_addr_onehot, 16'h0002);
    check("rel_s1_rsv_ready_same", rsv_ready, 1'b0);
    @(negedge clk);
    release_en = '0;
    #1;
    check("after_rel_rsv_ready", rsv_ready, 1'b1);
    check("after_rel_dcr_o", delay_calc_ready_out, 1'b1);
    check("after_rel_iid", rsv_iid, 1);
    rsv_valid         = 1'b1;
    rsv_req_id_onehot = 4'b0010;
    @(negedge clk);
    rsv_valid     = 1'b0;
    out_rsp_ready = 1'b0;

    // Slot 0 freed while a reservation waits: it takes effect one cycle later at iid 0.
    fill("fill_s0", 0, 32'h77);
    @(negedge clk);
    release_en        = 16'h0001;
    out_rsp_ready     = 1'b1;
    rsv_valid         = 1'b1;
    rsv_req_id_onehot = 4'b0001;
    #1;
    check("same_cycle_rsv_ready", rsv_ready, 1'b0);
    check("same_cycle_released", released_addr_onehot, 16'h0001);
    @(negedge clk);
    release_en = '0;
    #1;
    check("next_cycle_rsv_ready", rsv_ready, 1'b1);
    check("next_cycle_iid", rsv_iid, 0);
    @(negedge clk);
    rsv_valid     = 1'b0;
    out_rsp_ready = 1'b0;
    #1;
    check("refull_rsv_ready", rsv_ready, 1'b0);

    // Slots 3 and 5 released in slot order under a stalled consumer.
    do_reset("rst3");
    for (int i = 0; i < 6; i++) reserve("rsv_s", 0, i);
    for (int i = 0; i < 6; i++) fill("fill_s", 0, 32'h50 + i);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      release_en = 16'h0028;
`ifndef SIMMEM_RSP_BUF_OUT_REG_EN
      if (c >= 2) release_en = 16'h002B;
`endif
      #1;
`ifdef SIMMEM_RSP_BUF_OUT_REG_EN
      check("stall_released", released_addr_onehot, (c == 0) ? 16'h0008 : 16'h0000);
      check("stall_valid", out_rsp_valid, c != 0);
      if (c != 0) check("stall_data", rsp_out, 32'h53);
`else
      check("stall_released", released_addr_onehot, 16'h0000);
      check("stall_valid", out_rsp_valid, 1'b1);
      check("stall_data", rsp_out, 32'h53);
`endif
    end
    @(negedge clk);
    release_en    = 16'h0028;
    out_rsp_ready = 1'b1;
    #1;
    check("hs3_data", rsp_out, 32'h53);
`ifdef SIMMEM_RSP_BUF_OUT_REG_EN
    check("hs3_released", released_addr_onehot, 16'h0020);
`else
    check("hs3_released", released_addr_onehot, 16'h0008);
`endif
    @(negedge clk);
    #1;
    check("hs5_data", rsp_out, 32'h55);
    check("hs5_valid", out_rsp_valid, 1'b1);
`ifdef SIMMEM_RSP_BUF_OUT_REG_EN
    check("hs5_released", released_addr_onehot, 16'h0000);
`else
    check("hs5_released", released_addr_onehot, 16'h0020);
`endif
    @(negedge clk);
    #1;
    check("after5_valid", out_rsp_valid, 1'b0);
    @(negedge clk);
    release_en    = '0;
    out_rsp_ready = 1'b0;

    // Counter wrap: 2^5+3 round trips through slot 0 on ID0.
    do_reset("rst4");
    for (int i = 0; i < 35; i++) begin
      reserve("wrap_rsv", 0, 0);
      fill("wrap_fill", 0, 32'h1000 + i);
      exp_q.push_back('{32'h1000 + i, 16'h0001});
      drain("wrap_out", 16'h0001);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
